pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_seq_if.sv | 40 ++++
 rtl/pc_redirect_sel.sv | 58 +++++
 rtl/pc_seq.sv | 110 +++++++++++
 tb/tb_pc_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state and redirect-priority constants for the PC sequencer
//
// Purpose: one place for the RUN/HALT state encoding and the rank of each
// buffered redirect source. A larger rank wins. Exceptions are never
// buffered, so they have no rank here.

package pc_seq_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_RUN  = 1'b0;
    localparam state_t ST_HALT = 1'b1;

    typedef logic [1:0] pri_t;

    localparam pri_t PRI_NONE = 2'd0;
    localparam pri_t PRI_JMP  = 2'd1;
    localparam pri_t PRI_BR   = 2'd2;
    localparam pri_t PRI_ERET = 2'd3;

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - request/status bundle between a PC sequencer and its driver
//
// Purpose: groups the control requests, redirect targets and status outputs.
// Ports (slave view, i.e. the sequencer):
//   in : stall, halt_req, resume, exc_req, eret_req,
//        br_take, br_target[WIDTH], jmp_take, jmp_target[WIDTH]
//   out: pc[WIDTH], epc[WIDTH], halted, misalign, pend_valid

interface pc_seq_if #(
    parameter int WIDTH = 32
);

    logic             stall;
    logic             halt_req;
    logic             resume;
    logic             exc_req;
    logic             eret_req;
    logic             br_take;
    logic [WIDTH-1:0] br_target;
    logic             jmp_take;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic             halted;
    logic             misalign;
    logic             pend_valid;

    modport master (
        output stall, halt_req, resume, exc_req, eret_req,
               br_take, br_target, jmp_take, jmp_target,
        input  pc, epc, halted, misalign, pend_valid
    );

    modport slave (
        input  stall, halt_req, resume, exc_req, eret_req,
               br_take, br_target, jmp_take, jmp_target,
        output pc, epc, halted, misalign, pend_valid
    );

endinterface

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - combinational redirect priority and alignment filter
//
// Purpose: picks the highest-ranked non-exception redirect (eret > br > jmp)
// after discarding branch/jump targets whose low ALIGN_BITS bits are not zero.
// Ports:
//   in : eret_req, epc[WIDTH], br_take, br_target[WIDTH], jmp_take, jmp_target[WIDTH]
//   out: sel_valid, sel_pri (pri_t rank), sel_target[WIDTH],
//        bad_align (a taken br/jmp had a misaligned target)

module pc_redirect_sel
    import pc_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ALIGN_BITS = 2
) (
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_take,
    input  logic [WIDTH-1:0] jmp_target,
    output logic             sel_valid,
    output pri_t             sel_pri,
    output logic [WIDTH-1:0] sel_target,
    output logic             bad_align
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((1 << ALIGN_BITS) - 1);

    logic br_ok;
    logic jmp_ok;

    assign br_ok     = br_take  && ((br_target  & ALIGN_MASK) == '0);
    assign jmp_ok    = jmp_take && ((jmp_target & ALIGN_MASK) == '0);
    assign bad_align = (br_take && !br_ok) || (jmp_take && !jmp_ok);

    // A rejected redirect simply drops out, so a lower-ranked aligned one
    // (or the sequential step) takes its place.
    always_comb begin
        sel_valid  = 1'b0;
        sel_pri    = PRI_NONE;
        sel_target = '0;
        if (eret_req) begin
            sel_valid  = 1'b1;
            sel_pri    = PRI_ERET;
            sel_target = epc;
        end else if (br_ok) begin
            sel_valid  = 1'b1;
            sel_pri    = PRI_BR;
            sel_target = br_target;
        end else if (jmp_ok) begin
            sel_valid  = 1'b1;
            sel_pri    = PRI_JMP;
            sel_target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with stall buffering, halt and exceptions
//
// Purpose: registered PC updated on the falling clock edge. Handles exception
// entry/return, branch/jump redirects, a one-entry pending redirect buffer
// used while stalled, and a RUN/HALT state machine.
// Ports:
//   clk  : clock, state changes on the falling edge
//   rst  : asynchronous active-high reset
//   bus  : pc_seq_if.slave (requests in; pc/epc/halted/misalign/pend_valid out)

module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0004),
    parameter int               STEP         = 4,
    parameter int               ALIGN_BITS   = 2
) (
    input  logic    clk,
    input  logic    rst,
    pc_seq_if.slave bus
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] pend_target;
    pri_t             pend_pri;
    logic             pend_valid_q;
    logic             misalign_q;

    logic             sel_valid;
    pri_t             sel_pri;
    logic [WIDTH-1:0] sel_target;
    logic             bad_align;

    pc_redirect_sel #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_sel (
        .eret_req   (bus.eret_req),
        .epc        (epc_q),
        .br_take    (bus.br_take),
        .br_target  (bus.br_target),
        .jmp_take   (bus.jmp_take),
        .jmp_target (bus.jmp_target),
        .sel_valid  (sel_valid),
        .sel_pri    (sel_pri),
        .sel_target (sel_target),
        .bad_align  (bad_align)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            pend_target  <= '0;
            pend_pri     <= PRI_NONE;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            // Misaligned targets only matter where br/jmp are being looked at:
            // in RUN and not overridden by an exception.
            misalign_q <= (state == ST_RUN) && !bus.exc_req && bad_align;

            if (bus.exc_req) begin
                state        <= ST_RUN;
                pc_q         <= EXC_VECTOR;
                epc_q        <= pc_q & ~ALIGN_MASK;
                pend_valid_q <= 1'b0;
            end else if (state == ST_HALT) begin
                // Redirect inputs are ignored while halted; a pending entry
                // from before the halt is applied on resume unless stalled.
                if (bus.resume) begin
                    state <= ST_RUN;
                    if (pend_valid_q && !bus.stall) begin
                        pc_q         <= pend_target;
                        pend_valid_q <= 1'b0;
                    end
                end
            end else if (bus.halt_req) begin
                state <= ST_HALT;
            end else if (bus.stall) begin
                // Equal rank does not overwrite: the first request of a kind wins.
                if (sel_valid && (!pend_valid_q || (sel_pri > pend_pri))) begin
                    pend_target  <= sel_target;
                    pend_pri     <= sel_pri;
                    pend_valid_q <= 1'b1;
                end
            end else if (pend_valid_q) begin
                pc_q         <= (sel_valid && (sel_pri > pend_pri)) ? sel_target : pend_target;
                pend_valid_q <= 1'b0;
            end else begin
                pc_q <= sel_valid ? sel_target : pc_q + STEP_W;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.epc        = epc_q;
    assign bus.halted     = (state == ST_HALT);
    assign bus.misalign   = misalign_q;
    assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq

module tb_pc_seq;

    logic clk;
    logic rst;

    pc_seq_if #(.WIDTH(32)) bus ();
    pc_seq_if #(.WIDTH(8))  b8 ();

    pc_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pc_seq #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h00),
        .EXC_VECTOR   (8'h04),
        .STEP         (4),
        .ALIGN_BITS   (2)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural state following the written rules.
    logic [31:0] m_pc, m_epc, m_pend_tgt;
    bit          m_halted, m_pend_valid, m_mis;
    int          m_pend_rank;

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_pend_tgt = 32'h0;
        m_halted = 0; m_pend_valid = 0; m_mis = 0; m_pend_rank = 0;
    endtask

    // Advance the model by one falling edge with the inputs currently applied.
    task automatic model_edge();
        bit          have_new = 0;
        int          new_rank = 0;
        logic [31:0] new_tgt  = 32'h0;
        bit          br_bad, jmp_bad;
        br_bad  = bus.br_take  && (bus.br_target  % 4 != 0);
        jmp_bad = bus.jmp_take && (bus.jmp_target % 4 != 0);
        // Rank order: jmp 1, br 2, eret 3; the later assignment is the stronger one.
        if (bus.jmp_take && !jmp_bad) begin have_new = 1; new_rank = 1; new_tgt = bus.jmp_target; end
        if (bus.br_take  && !br_bad)  begin have_new = 1; new_rank = 2; new_tgt = bus.br_target;  end
        if (bus.eret_req)             begin have_new = 1; new_rank = 3; new_tgt = m_epc;          end
        m_mis = !m_halted && !bus.exc_req && (br_bad || jmp_bad);
        if (bus.exc_req) begin
            m_epc = m_pc; m_pc = 32'h4; m_pend_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            if (bus.resume) begin
                m_halted = 0;
                if (m_pend_valid && !bus.stall) begin m_pc = m_pend_tgt; m_pend_valid = 0; end
            end
        end else if (bus.halt_req) begin
            m_halted = 1;
        end else if (bus.stall) begin
            if (have_new && (!m_pend_valid || new_rank > m_pend_rank)) begin
                m_pend_valid = 1; m_pend_rank = new_rank; m_pend_tgt = new_tgt;
            end
        end else if (m_pend_valid) begin
            m_pc = (have_new && new_rank > m_pend_rank) ? new_tgt : m_pend_tgt;
            m_pend_valid = 0;
        end else if (have_new) begin
            m_pc = new_tgt;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.halt_req = 0; bus.resume = 0; bus.exc_req = 0; bus.eret_req = 0;
        bus.br_take = 0; bus.br_target = '0; bus.jmp_take = 0; bus.jmp_target = '0;
        b8.stall = 0; b8.halt_req = 0; b8.resume = 0; b8.exc_req = 0; b8.eret_req = 0;
        b8.br_take = 0; b8.br_target = '0; b8.jmp_take = 0; b8.jmp_target = '0;
    endtask

    // One falling edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #2;
        n_cmp++; if (bus.pc !== 32'h0)      begin n_fail++; $display("FAIL reset_pc actual=%h expected=%h", bus.pc, 32'h0); end
        n_cmp++; if (bus.epc !== 32'h0)     begin n_fail++; $display("FAIL reset_epc actual=%h expected=%h", bus.epc, 32'h0); end
        n_cmp++; if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend actual=%b expected=0", bus.pend_valid); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign actual=%b expected=0", bus.misalign); end
        n_cmp++; if (bus.halted !== 1'b0)   begin n_fail++; $display("FAIL reset_halted actual=%b expected=0", bus.halted); end
        @(posedge clk); rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL seq_pc0 actual=%h expected=%h", bus.pc, 32'h0); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_pc = 32'(i * 4);
            n_cmp++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, bus.pc, exp_pc); end
        end
    endtask

    task automatic test_stall_pending();
        // pc is 0x10 here
        bus.stall = 1; bus.br_take = 1; bus.br_target = 32'h40;
        tick();
        n_cmp++; if (bus.pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pend1 actual=%b expected=1", bus.pend_valid); end
        n_cmp++; if (bus.pc !== 32'h10)       begin n_fail++; $display("FAIL stall_hold1 actual=%h expected=%h", bus.pc, 32'h10); end
        bus.br_take = 0;
        tick();
        n_cmp++; if (bus.pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pend2 actual=%b expected=1", bus.pend_valid); end
        n_cmp++; if (bus.pc !== 32'h10)       begin n_fail++; $display("FAIL stall_hold2 actual=%h expected=%h", bus.pc, 32'h10); end
        bus.stall = 0;
        tick();
        n_cmp++; if (bus.pc !== 32'h40)       begin n_fail++; $display("FAIL stall_apply actual=%h expected=%h", bus.pc, 32'h40); end
        n_cmp++; if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL stall_clear actual=%b expected=0", bus.pend_valid); end
    endtask

    task automatic test_exception();
        bus.jmp_take = 1; bus.jmp_target = 32'h20;
        tick();
        n_cmp++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL exc_setup actual=%h expected=%h", bus.pc, 32'h20); end
        bus.jmp_take = 0; bus.exc_req = 1; bus.stall = 1;
        tick();
        n_cmp++; if (bus.pc !== 32'h4)  begin n_fail++; $display("FAIL exc_pc actual=%h expected=%h", bus.pc, 32'h4); end
        n_cmp++; if (bus.epc !== 32'h20) begin n_fail++; $display("FAIL exc_epc actual=%h expected=%h", bus.epc, 32'h20); end
        bus.exc_req = 0; bus.stall = 0;
        tick();
        n_cmp++; if (bus.pc !== 32'h8)  begin n_fail++; $display("FAIL exc_next actual=%h expected=%h", bus.pc, 32'h8); end
        bus.eret_req = 1;
        tick();
        n_cmp++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL eret_pc actual=%h expected=%h", bus.pc, 32'h20); end
        bus.eret_req = 0;
    endtask

    task automatic test_misalign();
        bus.jmp_take = 1; bus.jmp_target = 32'h42;
        tick();
        n_cmp++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse actual=%b expected=1", bus.misalign); end
        n_cmp++; if (bus.pc !== 32'h24)     begin n_fail++; $display("FAIL mis_pc actual=%h expected=%h", bus.pc, 32'h24); end
        bus.jmp_take = 0;
        tick();
        n_cmp++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL mis_end actual=%b expected=0", bus.misalign); end
        n_cmp++; if (bus.pc !== 32'h28)     begin n_fail++; $display("FAIL mis_pc2 actual=%h expected=%h", bus.pc, 32'h28); end
    endtask

    task automatic test_halt();
        bus.jmp_take = 1; bus.jmp_target = 32'h30;
        tick();
        bus.jmp_take = 0; bus.halt_req = 1;
        tick();
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter actual=%b expected=1", bus.halted); end
        n_cmp++; if (bus.pc !== 32'h30)   begin n_fail++; $display("FAIL halt_hold actual=%h expected=%h", bus.pc, 32'h30); end
        bus.halt_req = 0; bus.br_take = 1; bus.br_target = 32'h80;
        tick();
        n_cmp++; if (bus.pc !== 32'h30)   begin n_fail++; $display("FAIL halt_br_ignored actual=%h expected=%h", bus.pc, 32'h30); end
        bus.br_take = 0; bus.resume = 1; bus.halt_req = 1;
        tick();
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_resume actual=%b expected=0", bus.halted); end
        bus.resume = 0; bus.halt_req = 0;
        tick();
        n_cmp++; if (bus.pc !== 32'h34)   begin n_fail++; $display("FAIL halt_after actual=%h expected=%h", bus.pc, 32'h34); end
    endtask

    task automatic test_priority();
        // pc is 0x34, epc is 0x20
        bus.stall = 1; bus.jmp_take = 1; bus.jmp_target = 32'h100;
        tick();
        bus.jmp_take = 0; bus.br_take = 1; bus.br_target = 32'h200;
        tick();
        bus.br_take = 0; bus.jmp_take = 1; bus.jmp_target = 32'h300;
        tick();
        n_cmp++; if (bus.pc !== 32'h34) begin n_fail++; $display("FAIL prio_hold actual=%h expected=%h", bus.pc, 32'h34); end
        bus.stall = 0; bus.jmp_target = 32'h400;
        tick();
        n_cmp++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL prio_keep_br actual=%h expected=%h", bus.pc, 32'h200); end
        bus.jmp_take = 0; bus.stall = 1; bus.br_take = 1; bus.br_target = 32'h500;
        tick();
        bus.br_take = 0; bus.stall = 0; bus.eret_req = 1;
        tick();
        n_cmp++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL prio_eret_wins actual=%h expected=%h", bus.pc, 32'h20); end
        n_cmp++; if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL prio_pend_clear actual=%b expected=0", bus.pend_valid); end
        bus.eret_req = 0;
    endtask

    task automatic test_reset_discard();
        bus.stall = 1; bus.br_take = 1; bus.br_target = 32'h600;
        tick();
        bus.br_take = 0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend actual=%b expected=0", bus.pend_valid); end
        n_cmp++; if (bus.pc !== 32'h0)        begin n_fail++; $display("FAIL rst_pc actual=%h expected=%h", bus.pc, 32'h0); end
        bus.stall = 0;
        @(posedge clk); rst = 1'b0;
        #1;
        tick();
        n_cmp++; if (bus.pc !== 32'h4)        begin n_fail++; $display("FAIL rst_first actual=%h expected=%h", bus.pc, 32'h4); end
    endtask

    task automatic test_wrap();
        b8.jmp_take = 1; b8.jmp_target = 8'hFC;
        tick();
        n_cmp++; if (b8.pc !== 8'hFC) begin n_fail++; $display("FAIL wrap_setup actual=%h expected=%h", b8.pc, 8'hFC); end
        b8.jmp_take = 0;
        tick();
        n_cmp++; if (b8.pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc actual=%h expected=%h", b8.pc, 8'h00); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.stall      = ($urandom_range(0, 99) < 30);
            bus.halt_req   = ($urandom_range(0, 99) < 5);
            bus.resume     = ($urandom_range(0, 99) < 25);
            bus.exc_req    = ($urandom_range(0, 99) < 3);
            bus.eret_req   = ($urandom_range(0, 99) < 6);
            bus.br_take    = ($urandom_range(0, 99) < 20);
            bus.jmp_take   = ($urandom_range(0, 99) < 20);
            bus.br_target  = 32'($urandom_range(0, 1023) * 4 + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0));
            bus.jmp_target = 32'($urandom_range(0, 1023) * 4 + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0));
            tick();
            n_cmp++; if (bus.pc !== m_pc)                 begin n_fail++; $display("FAIL rand_pc[%0d] actual=%h expected=%h", i, bus.pc, m_pc); end
            n_cmp++; if (bus.epc !== m_epc)               begin n_fail++; $display("FAIL rand_epc[%0d] actual=%h expected=%h", i, bus.epc, m_epc); end
            n_cmp++; if (bus.halted !== m_halted)         begin n_fail++; $display("FAIL rand_halted[%0d] actual=%b expected=%b", i, bus.halted, m_halted); end
            n_cmp++; if (bus.pend_valid !== m_pend_valid) begin n_fail++; $display("FAIL rand_pend[%0d] actual=%b expected=%b", i, bus.pend_valid, m_pend_valid); end
            n_cmp++; if (bus.misalign !== m_mis)          begin n_fail++; $display("FAIL rand_misalign[%0d] actual=%b expected=%b", i, bus.misalign, m_mis); end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_stall_pending();
        test_exception();
        test_misalign();
        test_halt();
        test_priority();
        test_reset_discard();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
